// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract accumulator slice: FSM state
// encoding, the default datapath width and the saturation limits used when
// the design is built with ADDSUB_ACC_SAT_EN.
package addsub_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Largest positive and most negative two's-complement values at DEF_WIDTH.
    localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/addsub_flags.sv
// Combinational result/status logic for the accumulator. Takes the
// pre-update accumulator plus the adder outputs and produces the next
// accumulator value together with carry/overflow/zero/negative.
// Optional macro ADDSUB_ACC_SAT_EN: saturate the accumulator on overflow
// instead of wrapping.
module addsub_flags #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] acc_old,
    input  logic [WIDTH-1:0] effb,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    input  logic             sub_q,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

`ifdef ADDSUB_ACC_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp to the signed range; overflow direction follows the sign of the
    // operand that was already in the accumulator.
    function automatic logic [WIDTH-1:0] saturate(input logic             of,
                                                  input logic signed [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] s);
        if (!of)
            return s;
        else if (a < 0)
            return SAT_LO;
        else
            return SAT_HI;
    endfunction
`endif

    // Flags and next accumulator value for the EXEC cycle.
    always_comb begin
        carry = add_cout ^ sub_q;
        ovf   = (acc_old[WIDTH-1] == effb[WIDTH-1]) && (add_s[WIDTH-1] != acc_old[WIDTH-1]);
`ifdef ADDSUB_ACC_SAT_EN
        acc_nxt = saturate(ovf, $signed(acc_old), add_s);
`else
        acc_nxt = add_s;
`endif
        zero  = (acc_nxt == '0);
        neg   = acc_nxt[WIDTH-1];
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator wrapped around an external combinational
// add/subtract unit (fourbit_addsub). One operand is accepted in IDLE, the
// adder result is captured in EXEC, and the result is held in RESP until the
// consumer takes it. Optional macro ADDSUB_ACC_SAT_EN enables saturation.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             zero_flag,
    output logic             neg_flag
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic [WIDTH-1:0] effb;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry_nxt, ovf_nxt, zero_nxt, neg_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);

    // The adder inputs are always driven from registers so they never float.
    assign add_a   = acc;
    assign add_b   = b_q;
    assign add_sub = sub_q;
    assign effb    = b_q ^ {WIDTH{sub_q}};

    addsub_flags #(.WIDTH(WIDTH)) u_flags (
        .acc_old  (acc),
        .effb     (effb),
        .add_s    (add_s),
        .add_cout (add_cout),
        .sub_q    (sub_q),
        .acc_nxt  (acc_nxt),
        .carry    (carry_nxt),
        .ovf      (ovf_nxt),
        .zero     (zero_nxt),
        .neg      (neg_nxt)
    );

    // Next-state logic; clr aborts any operation back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr)
            state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand capture in IDLE and accumulator/flag update in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            zero_flag  <= 1'b0;
            neg_flag   <= 1'b0;
        end else if (clr) begin
            acc        <= '0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            zero_flag  <= 1'b0;
            neg_flag   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                b_q   <= in_b;
                sub_q <= in_sub;
            end
            if (state == EXEC) begin
                acc        <= acc_nxt;
                carry_flag <= carry_nxt;
                ovf_flag   <= ovf_nxt;
                zero_flag  <= zero_nxt;
                neg_flag   <= neg_nxt;
            end
        end
    end

endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
- Sequential wrapper that sits directly around fourbit_addsub, both upstream and downstream of it.
- Upstream role: drives the adder's a/b/sub inputs from a running accumulator and a handshaked operand.
- Downstream role: registers the adder's s/cout into the accumulator and produces carry/overflow/zero/negative status.
- Downstream consumers receive the result via a valid/ready handshake.

Parameters:
- WIDTH, 4, datapath width; must equal the adder width (4) when instantiated with fourbit_addsub.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear of accumulator and flags
- in_valid  input  1  operand valid
- in_ready  output  1  operand accepted when in_valid && in_ready
- in_b  input  WIDTH  operand B
- in_sub  input  1  1 = acc − in_b, 0 = acc + in_b
- add_a  output  WIDTH  to adder a
- add_b  output  WIDTH  to adder b
- add_sub  output  1  to adder sub
- add_s  input  WIDTH  from adder s
- add_cout  input  1  from adder cout
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- acc  output  WIDTH  accumulator value
- carry_flag  output  1  carry (add) / borrow (sub)
- ovf_flag  output  1  two's-complement overflow
- zero_flag  output  1  acc == 0
- neg_flag  output  1  acc[WIDTH-1]

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; acc, b_q, sub_q and all flags = 0; out_valid=0.
- Consequently during reset in_ready=1, add_a=0, add_b=0, add_sub=0.
- States: IDLE, EXEC, RESP.
- in_ready = (state==IDLE), combinational from state.
- out_valid = (state==RESP).
- IDLE: on in_valid && in_ready, latch b_q=in_b and sub_q=in_sub; go to EXEC. Otherwise stay.
- EXEC (exactly 1 cycle):
  - add_a=acc, add_b=b_q, add_sub=sub_q.
  - Adder is combinational; sample add_s/add_cout at the end of the cycle.
  - Update acc and all flags; go to RESP.
- RESP: hold acc and flags stable; go to IDLE on the edge where out_ready=1.
- Outside EXEC, add_a=acc, add_b=b_q and add_sub=sub_q are still driven. The values are don't-care to the adder but must be stable (no X).
- Latency and throughput:
  - Accept at edge k → acc/flags updated at edge k+1 → out_valid high from cycle k+1.
  - Minimum 3 cycles per operation; no overlap (in_ready=0 in EXEC/RESP).
- Flag rules (effB = b_q XOR {WIDTH{sub_q}}):
  - carry_flag = add_cout XOR sub_q (1 = carry out on add, 1 = borrow on sub).
  - ovf_flag = (acc[MSB]==effB[MSB]) && (add_s[MSB]!=acc[MSB]), evaluated on the pre-update acc.
  - zero_flag and neg_flag are computed from the new (post-update, post-saturation) acc.
- Arithmetic is modulo 2^WIDTH unless the optional feature is enabled.
- clr has priority over everything except rst_n, in any state, at the next edge:
  - acc=0, flags=0, state=IDLE; an in-flight operation is discarded with no out_valid pulse.
  - clr && in_valid in IDLE: clr wins, operand is not accepted.
- rst_n low mid-operation (EXEC/RESP): immediate asynchronous return to reset values; out_valid drops without a handshake.
- in_valid or in_b changes while in_ready=0 are ignored; b_q is held.

Optional Feature:
- Macro: ADDSUB_ACC_SAT_EN.
- Defined: on ovf, acc saturates instead of wrapping.
  - Positive overflow (acc[MSB]=0) → 0111.
  - Negative overflow (acc[MSB]=1) → 1000.
  - ovf_flag is still set; carry_flag is unchanged; zero/neg follow the saturated value.
- Undefined: acc <= add_s (wrap); no saturation logic is synthesised.

Decomposition:
- Package addsub_pkg:
  - State encoding localparams (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - Default WIDTH.
  - Saturation constants SAT_MAX (0111) and SAT_MIN (1000), both WIDTH-parameterised.
- One sub-module, addsub_flags: combinational.
  - Inputs: acc_old, effB, add_s, add_cout, sub_q.
  - Outputs: next acc (saturation under the macro), carry, ovf, zero, neg.
- The top holds the FSM and registers only.

Test Plan:
- Reset, then in_b=0011, in_sub=0 → out_valid high 1 cycle after the accept edge; acc=0011; carry=0, ovf=0, zero=0, neg=0.
- acc=0011, in_b=0011, in_sub=1 → acc=0000; zero=1; carry_flag=0 (cout=1, no borrow); ovf=0.
- acc=0000, in_b=0001, in_sub=1 → acc=1111; neg=1; carry_flag=1 (borrow); ovf=0.
- acc=0111, in_b=0001, in_sub=0 → acc=1000, ovf=1, neg=1, carry=0. With ADDSUB_ACC_SAT_EN: acc=0111, ovf=1, neg=0.
- out_ready held 0 for 5 cycles in RESP, in_valid=1 with in_b=0101 → out_valid stays 1, acc unchanged, in_ready=0, operand not taken. out_ready=1 → IDLE next cycle, then accept.
- Assert clr during EXEC → acc=0, flags=0, no out_valid pulse. Separately, rst_n=0 mid-RESP → out_valid=0 and acc=0 immediately, without waiting for a clock edge.
